rect_overlay: RTL and testbench

- Parametrised rectangle compositor replacing the hard-wired combinational square logic in the screen top level.
- Consumes pixel coordinates and syncs from pixel_itr and holds NUM_RECTS programmable rectangles, each with its own colour, enable and blink control.
- Produces pipelined RGB plus delay-matched syncs.
- Configuration goes into shadow registers and commits atomically once per frame, so there is no tearing.

---
 rtl/vga_overlay_pkg.sv | 29 ++
 rtl/rect_hit.sv | 22 ++
 rtl/rect_overlay.sv | 153 +++++++++++++++
 tb/tb_rect_overlay.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_overlay_pkg.sv
// Shared definitions for the rectangle overlay: config field encodings,
// ctrl bit positions and the per-rectangle configuration record.
package vga_overlay_pkg;

  localparam int unsigned RECT_COORD_W = 13;
  localparam int unsigned RECT_CH_W    = 1;
  localparam int unsigned RECT_COL_W   = 3 * RECT_CH_W;

  localparam logic [2:0] FLD_X0     = 3'd0;
  localparam logic [2:0] FLD_Y0     = 3'd1;
  localparam logic [2:0] FLD_X1     = 3'd2;
  localparam logic [2:0] FLD_Y1     = 3'd3;
  localparam logic [2:0] FLD_COLOUR = 3'd4;
  localparam logic [2:0] FLD_CTRL   = 3'd5;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_BLINK = 1;

  typedef struct packed {
    logic [RECT_COORD_W-1:0] x0;
    logic [RECT_COORD_W-1:0] y0;
    logic [RECT_COORD_W-1:0] x1;
    logic [RECT_COORD_W-1:0] y1;
    logic [RECT_COL_W-1:0]   colour;
    logic                    en;
    logic                    blink;
  } rect_cfg_t;

endpackage

// File: rtl/rect_hit.sv
// Combinational hit test of one pixel against one rectangle's interior.
module rect_hit
  import vga_overlay_pkg::*;
(
  input  logic [RECT_COORD_W-1:0] i_pix_x,
  input  logic [RECT_COORD_W-1:0] i_pix_y,
  input  rect_cfg_t               i_cfg,
  input  logic                    i_blink_phase,
  output logic                    o_hit_c
);

  logic w_live;
  logic w_in_x;
  logic w_in_y;

  // Strict bounds on both sides also reject degenerate rectangles.
  assign w_live  = i_cfg.en && !(i_cfg.blink && i_blink_phase);
  assign w_in_x  = (i_cfg.x0 < i_pix_x) && (i_pix_x < i_cfg.x1);
  assign w_in_y  = (i_cfg.y0 < i_pix_y) && (i_pix_y < i_cfg.y1);
  assign o_hit_c = w_live && w_in_x && w_in_y;

endmodule

// File: rtl/rect_overlay.sv
// Rectangle compositor: shadow/active config banks committed once per frame,
// per-rectangle hit test, priority colour mux and a 2-stage pixel pipeline.
module rect_overlay
  import vga_overlay_pkg::*;
#(
  parameter int unsigned NUM_RECTS    = 4,
  parameter int unsigned COORD_W      = RECT_COORD_W,
  parameter int unsigned CH_W         = RECT_CH_W,
  parameter int unsigned H_VISIBLE    = 800,
  parameter int unsigned V_VISIBLE    = 600,
  parameter bit          HS_ACTIVE    = 1'b0,
  parameter bit          VS_ACTIVE    = 1'b0,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned IDX_W        = $clog2(NUM_RECTS + 1),
  parameter int unsigned WD_W         = (COORD_W > 3 * CH_W) ? COORD_W : 3 * CH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [2:0]         cfg_field,
  input  logic [WD_W-1:0]    cfg_wdata,
  output logic               h_sync,
  output logic               v_sync,
  output logic [CH_W-1:0]    r_out,
  output logic [CH_W-1:0]    g_out,
  output logic [CH_W-1:0]    b_out,
  output logic               frame_tick
);

  localparam int unsigned COL_W = 3 * CH_W;
  localparam int unsigned BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  rect_cfg_t          r_shadow [NUM_RECTS];
  rect_cfg_t          r_active [NUM_RECTS];
  logic [COL_W-1:0]   r_bg_shadow;
  logic [COL_W-1:0]   r_bg_active;
  logic               r_vs_prev;
  logic [BC_W-1:0]    r_blink_cnt;
  logic               r_blink_phase;
  logic [NUM_RECTS-1:0] r_hit_s1;
  logic               r_vis_s1;
  logic               r_hs_s1;
  logic               r_vs_s1;

  logic                 w_commit;
  logic                 w_visible;
  logic [NUM_RECTS-1:0] w_hit;
  logic [COL_W-1:0]     w_colour;

  // Commit on the trailing edge of the vertical sync pulse.
  assign w_commit  = (r_vs_prev == VS_ACTIVE) && (v_sync_in != VS_ACTIVE);
  assign w_visible = (pix_x < COORD_W'(H_VISIBLE)) && (pix_y < COORD_W'(V_VISIBLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_RECTS); i++) r_shadow[i] <= '0;
      r_bg_shadow <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < int'(NUM_RECTS); i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          case (cfg_field)
            FLD_X0:     r_shadow[i].x0     <= cfg_wdata[COORD_W-1:0];
            FLD_Y0:     r_shadow[i].y0     <= cfg_wdata[COORD_W-1:0];
            FLD_X1:     r_shadow[i].x1     <= cfg_wdata[COORD_W-1:0];
            FLD_Y1:     r_shadow[i].y1     <= cfg_wdata[COORD_W-1:0];
            FLD_COLOUR: r_shadow[i].colour <= cfg_wdata[COL_W-1:0];
            FLD_CTRL: begin
              r_shadow[i].en    <= cfg_wdata[CTRL_EN];
              r_shadow[i].blink <= cfg_wdata[CTRL_BLINK];
            end
            default: ;
          endcase
        end
      end
      if ((cfg_idx == IDX_W'(NUM_RECTS)) && (cfg_field == FLD_COLOUR))
        r_bg_shadow <= cfg_wdata[COL_W-1:0];
    end
  end

  // Active bank, blink state and frame tick only move at a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_RECTS); i++) r_active[i] <= '0;
      r_bg_active   <= '0;
      r_vs_prev     <= !VS_ACTIVE;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      r_vs_prev  <= v_sync_in;
      frame_tick <= w_commit;
      if (w_commit) begin
        for (int i = 0; i < int'(NUM_RECTS); i++) r_active[i] <= r_shadow[i];
        r_bg_active <= r_bg_shadow;
        if (r_blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= !r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BC_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_RECTS); g++) begin : g_hit
    rect_hit u_hit (
      .i_pix_x       (pix_x),
      .i_pix_y       (pix_y),
      .i_cfg         (r_active[g]),
      .i_blink_phase (r_blink_phase),
      .o_hit_c       (w_hit[g])
    );
  end

  // Lowest index wins: scan from the top so index 0 overrides last.
  always_comb begin
    w_colour = r_bg_active;
    for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
      if (r_hit_s1[i]) w_colour = r_active[i].colour;
    end
    if (!r_vis_s1) w_colour = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_s1 <= '0;
      r_vis_s1 <= 1'b0;
      r_hs_s1  <= !HS_ACTIVE;
      r_vs_s1  <= !VS_ACTIVE;
      h_sync   <= !HS_ACTIVE;
      v_sync   <= !VS_ACTIVE;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
    end else begin
      r_hit_s1 <= w_hit;
      r_vis_s1 <= w_visible;
      r_hs_s1  <= h_sync_in;
      r_vs_s1  <= v_sync_in;
      h_sync   <= r_hs_s1;
      v_sync   <= r_vs_s1;
      r_out    <= w_colour[COL_W-1:2*CH_W];
      g_out    <= w_colour[2*CH_W-1:CH_W];
      b_out    <= w_colour[CH_W-1:0];
    end
  end

endmodule

// File: tb/tb_rect_overlay.sv
// Directed bench for rect_overlay: table of pixel vectors per config phase
// plus hand sequences for commit timing, sync delay, blink and reset.
module tb_rect_overlay;

  logic        clk;
  logic        rst;
  logic [12:0] pix_x;
  logic [12:0] pix_y;
  logic        h_sync_in;
  logic        v_sync_in;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [2:0]  cfg_field;
  logic [12:0] cfg_wdata;
  logic        h_sync;
  logic        v_sync;
  logic        r_out;
  logic        g_out;
  logic        b_out;
  logic        frame_tick;

  rect_overlay #(.BLINK_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_field  (cfg_field),
    .cfg_wdata  (cfg_wdata),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .r_out      (r_out),
    .g_out      (g_out),
    .b_out      (b_out),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         ph;
    int         x;
    int         y;
    logic [2:0] exp;
  } vec_t;

  vec_t vt [15];

  int n_cmp;
  int n_err;

  // Bench-side model of sync delay line, commit detection and blink phase.
  logic m_vs_prev;
  logic m_hs_d1, m_hs_d2, m_vs_d1, m_vs_d2;
  logic m_ft;
  int   m_commits;

  function automatic logic [2:0] rgb();
    return {r_out, g_out, b_out};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vs_prev = 1'b1;
    m_hs_d1 = 1'b1; m_hs_d2 = 1'b1;
    m_vs_d1 = 1'b1; m_vs_d2 = 1'b1;
    m_ft = 1'b0;
    m_commits = 0;
  endtask

  task automatic tick();
    logic c;
    c = (m_vs_prev == 1'b0) && (v_sync_in == 1'b1);
    m_vs_prev = v_sync_in;
    m_hs_d2 = m_hs_d1; m_hs_d1 = h_sync_in;
    m_vs_d2 = m_vs_d1; m_vs_d1 = v_sync_in;
    @(posedge clk);
    #1;
    m_ft = c;
    if (c) m_commits++;
  endtask

  task automatic cfg(input int idx, input int fld, input int data);
    cfg_we    = 1'b1;
    cfg_idx   = 3'(idx);
    cfg_field = 3'(fld);
    cfg_wdata = 13'(data);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic set_rect(input int idx, input int x0, input int y0, input int x1,
                          input int y1, input int col, input int ctrl);
    cfg(idx, 0, x0); cfg(idx, 1, y0); cfg(idx, 2, x1); cfg(idx, 3, y1);
    cfg(idx, 4, col); cfg(idx, 5, ctrl);
  endtask

  task automatic commit();
    v_sync_in = 1'b0;
    tick();
    v_sync_in = 1'b1;
    tick();
    chk("commit_tick", int'(frame_tick), int'(m_ft));
    tick();
    chk("tick_width", int'(frame_tick), 0);
  endtask

  task automatic pix(input int x, input int y, output logic [2:0] c);
    pix_x = 13'(x);
    pix_y = 13'(y);
    tick();
    tick();
    c = rgb();
  endtask

  task automatic run_table(input int ph);
    logic [2:0] c;
    for (int i = 0; i < 15; i++) begin
      if (vt[i].ph == ph) begin
        pix(vt[i].x, vt[i].y, c);
        chk($sformatf("vec%0d(%0d,%0d)", i, vt[i].x, vt[i].y), int'(c), int'(vt[i].exp));
      end
    end
  endtask

  initial begin
    logic [2:0] c;
    logic [2:0] exp_blink;
    n_cmp = 0;
    n_err = 0;

    vt[0]  = '{1, 256, 41, 3'b100};
    vt[1]  = '{1, 255, 41, 3'b000};
    vt[2]  = '{1, 305, 41, 3'b000};
    vt[3]  = '{1, 304, 89, 3'b100};
    vt[4]  = '{1, 256, 40, 3'b000};
    vt[5]  = '{1, 280, 90, 3'b000};
    vt[6]  = '{2, 300, 60, 3'b100};
    vt[7]  = '{2, 260, 35, 3'b010};
    vt[8]  = '{2, 500, 60, 3'b001};
    vt[9]  = '{2, 900, 60, 3'b000};
    vt[10] = '{2, 500, 700, 3'b000};
    vt[11] = '{2, 799, 599, 3'b001};
    vt[12] = '{2, 800, 10, 3'b000};
    vt[13] = '{2, 251, 31, 3'b010};
    vt[14] = '{2, 250, 31, 3'b001};

    rst = 1'b1;
    pix_x = '0; pix_y = '0;
    h_sync_in = 1'b1; v_sync_in = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0; cfg_wdata = '0;
    model_reset();

    repeat (10) @(posedge clk);
    #1;
    chk("rst_rgb", int'(rgb()), 0);
    chk("rst_hs", int'(h_sync), 1);
    chk("rst_vs", int'(v_sync), 1);
    chk("rst_tick", int'(frame_tick), 0);
    rst = 1'b0;

    // Free-running syncs with no config: black output, 2-cycle sync delay.
    for (int k = 0; k < 40; k++) begin
      h_sync_in = (k % 10) >= 2;
      v_sync_in = (k % 20) >= 3;
      pix_x = 13'(k * 20);
      pix_y = 13'(k * 15);
      tick();
      chk("pipe_hs", int'(h_sync), int'(m_hs_d2));
      chk("pipe_vs", int'(v_sync), int'(m_vs_d2));
      chk("pipe_tick", int'(frame_tick), int'(m_ft));
      chk("pipe_rgb", int'(rgb()), 0);
    end
    h_sync_in = 1'b1; v_sync_in = 1'b1;
    tick();

    // Rect0 written mid-frame stays invisible until the next commit.
    set_rect(0, 255, 40, 305, 90, 3'b100, 1);
    pix(256, 41, c);
    chk("shadow_only", int'(c), 0);
    commit();
    run_table(1);

    set_rect(1, 250, 30, 400, 100, 3'b010, 1);
    cfg(4, 4, 3'b001);
    commit();
    run_table(2);

    cfg(0, 5, 0);
    commit();
    pix(300, 60, c);
    chk("rect0_off", int'(c), 3'b010);

    // Out-of-range index/field and non-colour background fields are dropped.
    cfg(5, 4, 3'b111);
    cfg(5, 5, 3);
    cfg(0, 7, 3);
    cfg(0, 6, 3);
    cfg(4, 0, 0);
    cfg(4, 5, 3);
    commit();
    pix(300, 60, c);
    chk("ign_overlap", int'(c), 3'b010);
    pix(500, 60, c);
    chk("ign_bg", int'(c), 3'b001);
    pix(256, 41, c);
    chk("ign_rect0", int'(c), 3'b010);

    // Write on the commit edge itself lands one frame late.
    v_sync_in = 1'b0;
    tick();
    v_sync_in = 1'b1;
    cfg(4, 4, 3'b110);
    chk("coinc_tick", int'(frame_tick), 1);
    pix(500, 60, c);
    chk("coinc_late", int'(c), 3'b001);
    commit();
    pix(500, 60, c);
    chk("coinc_next", int'(c), 3'b110);

    // Blink with BLINK_FRAMES=2: phase toggles on every second commit.
    set_rect(2, 600, 200, 700, 300, 3'b011, 3);
    for (int f = 0; f < 6; f++) begin
      commit();
      exp_blink = (((m_commits / 2) % 2) == 0) ? 3'b011 : 3'b110;
      pix(650, 250, c);
      chk($sformatf("blink_f%0d", f), int'(c), int'(exp_blink));
    end

    // Async reset mid-frame clears outputs at once and banks to background 0.
    pix_x = 13'd650; pix_y = 13'd250;
    rst = 1'b1;
    #1;
    chk("arst_rgb", int'(rgb()), 0);
    chk("arst_tick", int'(frame_tick), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    pix(650, 250, c);
    chk("post_rst_rect", int'(c), 0);
    pix(500, 60, c);
    chk("post_rst_bg", int'(c), 0);
    commit();
    pix(650, 250, c);
    chk("post_rst_commit", int'(c), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
